execute_cycle: RTL
==================

Name: execute_cycle

Overview:
- Execute (E) stage of the 5-stage RV32I pipeline. It sits directly downstream of the decode stage and consumes its ID/EX register outputs.
- Functions: operand forwarding muxes, ALU, branch/jump target and redirect decision, and the EX/MEM pipeline register that feeds the memory stage.
- PCSrcE and PCTargetE return to the fetch stage. ALUResultM is both the forwarding source for this stage and the memory address for the memory stage.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- RegWriteE  in  1  register write enable from decode
- ALUSrcE  in  1  ALU B source: 0 = forwarded rs2, 1 = immediate
- MemWriteE  in  1  store enable
- ResultSrcE  in  2  writeback select: 00 = ALU, 01 = memory, 10 = PC+4
- BranchE  in  1  conditional branch (BEQ)
- JumpE  in  1  JAL
- ALUControlE  in  3  ALU operation
- RD1_E, RD2_E  in  XLEN  register file read data
- Imm_Ext_E  in  XLEN  extended immediate
- RD_E, RS1_E, RS2_E  in  5  register indices (RS1_E/RS2_E are used only by the hazard unit, so they are not consumed here)
- PCE, PCPlus4E  in  XLEN  instruction PC and PC+4
- ForwardAE, ForwardBE  in  2  forward selects from the hazard unit
- ResultW  in  XLEN  writeback-stage result
- FlushM  in  1  insert a bubble into EX/MEM
- PCSrcE  out  1  redirect fetch
- PCTargetE  out  XLEN  redirect target
- RegWriteM, MemWriteM  out  1  registered controls
- ResultSrcM  out  2  registered writeback select
- RD_M  out  5  registered destination register
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered data

Behaviour:
- Forwarding (combinational):
  - SrcAE = ForwardAE: 00 → RD1_E; 01 → ResultW; 10 → ALUResultM (this block's own registered output); 11 → RD1_E.
  - WriteDataE = same mux on ForwardBE using RD2_E.
  - SrcBE = ALUSrcE ? Imm_Ext_E : WriteDataE.
- ALU (combinational, 32-bit, result wraps modulo 2^32):
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed; result 1 or 0)
  - 110 SLL by SrcBE[4:0]
  - 111 SRL by SrcBE[4:0]
  - ZeroE = (ALUResultE == 0).
- Redirect (combinational, same cycle as E):
  - PCTargetE = PCE + Imm_Ext_E (wraps).
  - PCSrcE = (BranchE & ZeroE) | JumpE.
  - Both are independent of FlushM.
- EX/MEM register (posedge clk, async clear on rst low):
  - rst low: every M output is 0 immediately, without waiting for a clock edge. This also holds for reset asserted mid-operation.
  - FlushM high at the edge: RegWriteM = 0, MemWriteM = 0, ResultSrcM = 00, RD_M = 0, and ALUResultM = WriteDataM = PCPlus4M = 0.
  - Otherwise M outputs load: RegWriteE, MemWriteE, ResultSrcE, RD_E, ALUResultE, WriteDataE (forwarded rs2, not the immediate), PCPlus4E.
  - If rst and FlushM are both active, reset dominates.
- Latency:
  - One cycle from E inputs to M outputs.
  - Forwarding from ALUResultM gives back-to-back dependent ALU ops with zero stall.
- JALR is out of scope. Jump always uses PCE + imm.
- No stall input: the hazard unit stalls upstream and flushes the E input registers. A flushed E-stage bundle (all zero) flows through as a harmless ADD x0.

Test Plan:
- Reset: hold rst = 0 with nonzero inputs → all M outputs 0, no clock edge needed. Release rst with RegWriteE = 1, RD_E = 5, ADD 3 + 4 → next edge: ALUResultM = 7, RD_M = 5, RegWriteM = 1.
- Forwarding: cycle 1 ADD RD1_E = 10, imm = 5 → ALUResultM = 15. Cycle 2 ForwardAE = 10, ALUSrcE = 0, RD2_E = 1, SUB → ALUResultM = 14. Then ForwardBE = 01, ResultW = 0xFFFFFFFF, XOR with A = 0x0F0F0F0F → 0xF0F0F0F0.
- Branch: BranchE = 1, SUB 8 − 8, PCE = 0x100, imm = 0x20 → PCSrcE = 1, PCTargetE = 0x120. With operands 8 − 7 → PCSrcE = 0.
- Jump: JumpE = 1, ResultSrcE = 10, PCE = 0x40, PCPlus4E = 0x44, imm = −8 → PCSrcE = 1, PCTargetE = 0x38, next edge PCPlus4M = 0x44, ResultSrcM = 10.
- Flush and store data: MemWriteE = 1, ALUSrcE = 1, RD2_E = 0xAB, FlushM = 1 → next edge MemWriteM = 0, WriteDataM = 0. Same inputs with FlushM = 0 → MemWriteM = 1, WriteDataM = 0xAB.
- ALU corners:
  - SLT(−1, 1) = 1, SLT(1, −1) = 0
  - SLL(1, 31) = 0x80000000
  - SRL(0x80000000, 35) = 0x10000000 (shift amount 3)
  - ADD(0xFFFFFFFF, 1) = 0 with ZeroE = 1

Source files
------------

// File: rtl/execute_cycle_if.sv
// Bundle of signals between the ID/EX register, the hazard unit, the execute
// stage and the EX/MEM consumers. The master side drives the E-stage inputs
// and observes the registered M-stage outputs; the slave side is the stage.
interface execute_cycle_if #(
   parameter int XLEN = 32
);

   logic            RegWriteE;
   logic            ALUSrcE;
   logic            MemWriteE;
   logic [1:0]      ResultSrcE;
   logic            BranchE;
   logic            JumpE;
   logic [2:0]      ALUControlE;
   logic [XLEN-1:0] RD1_E;
   logic [XLEN-1:0] RD2_E;
   logic [XLEN-1:0] Imm_Ext_E;
   logic [4:0]      RD_E;
   logic [4:0]      RS1_E;
   logic [4:0]      RS2_E;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic [XLEN-1:0] ResultW;
   logic            FlushM;

   logic            PCSrcE;
   logic [XLEN-1:0] PCTargetE;
   logic            RegWriteM;
   logic            MemWriteM;
   logic [1:0]      ResultSrcM;
   logic [4:0]      RD_M;
   logic [XLEN-1:0] ALUResultM;
   logic [XLEN-1:0] WriteDataM;
   logic [XLEN-1:0] PCPlus4M;

   modport master (
      output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE,
             ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E,
             PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW, FlushM,
      input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             ALUResultM, WriteDataM, PCPlus4M
   );

   modport slave (
      input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE,
             ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E,
             PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW, FlushM,
      output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             ALUResultM, WriteDataM, PCPlus4M
   );

endinterface

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump redirect to fetch, and the EX/MEM pipeline register.
// RS1_E/RS2_E travel in the bundle for the hazard unit and are not used here.
module execute_cycle #(
   parameter int XLEN = 32
) (
   input logic clk,
   input logic rst,
   execute_cycle_if.slave bus
);

   logic [XLEN-1:0] srcAE;
   logic [XLEN-1:0] srcBE;
   logic [XLEN-1:0] writeDataE;
   logic [XLEN-1:0] aluResultE;
   logic            zeroE;

   // Forwarding muxes pick the freshest copy of rs1/rs2 (own EX/MEM result or writeback)
   always_comb begin
      srcAE = bus.RD1_E;
      case (bus.ForwardAE)
         2'b01:   srcAE = bus.ResultW;
         2'b10:   srcAE = bus.ALUResultM;
         default: srcAE = bus.RD1_E;
      endcase

      writeDataE = bus.RD2_E;
      case (bus.ForwardBE)
         2'b01:   writeDataE = bus.ResultW;
         2'b10:   writeDataE = bus.ALUResultM;
         default: writeDataE = bus.RD2_E;
      endcase

      srcBE = bus.ALUSrcE ? bus.Imm_Ext_E : writeDataE;
   end

   // ALU; shifts only honour the low five bits of the B operand
   always_comb begin
      aluResultE = '0;
      case (bus.ALUControlE)
         3'b000:  aluResultE = srcAE + srcBE;
         3'b001:  aluResultE = srcAE - srcBE;
         3'b010:  aluResultE = srcAE & srcBE;
         3'b011:  aluResultE = srcAE | srcBE;
         3'b100:  aluResultE = srcAE ^ srcBE;
         3'b101:  aluResultE = {{(XLEN-1){1'b0}}, ($signed(srcAE) < $signed(srcBE))};
         3'b110:  aluResultE = srcAE << srcBE[4:0];
         3'b111:  aluResultE = srcAE >> srcBE[4:0];
         default: aluResultE = srcAE + srcBE;
      endcase
   end

   assign zeroE         = (aluResultE == '0);
   assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
   assign bus.PCSrcE    = (bus.BranchE & zeroE) | bus.JumpE;

   // EX/MEM register: async clear on reset, bubble on flush, otherwise capture E results
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.RegWriteM  <= 1'b0;
         bus.MemWriteM  <= 1'b0;
         bus.ResultSrcM <= 2'b00;
         bus.RD_M       <= 5'd0;
         bus.ALUResultM <= '0;
         bus.WriteDataM <= '0;
         bus.PCPlus4M   <= '0;
      end else if (bus.FlushM) begin
         bus.RegWriteM  <= 1'b0;
         bus.MemWriteM  <= 1'b0;
         bus.ResultSrcM <= 2'b00;
         bus.RD_M       <= 5'd0;
         bus.ALUResultM <= '0;
         bus.WriteDataM <= '0;
         bus.PCPlus4M   <= '0;
      end else begin
         bus.RegWriteM  <= bus.RegWriteE;
         bus.MemWriteM  <= bus.MemWriteE;
         bus.ResultSrcM <= bus.ResultSrcE;
         bus.RD_M       <= bus.RD_E;
         bus.ALUResultM <= aluResultE;
         bus.WriteDataM <= writeDataE;
         bus.PCPlus4M   <= bus.PCPlus4E;
      end
   end

endmodule
